// File: rtl/wb_uart.sv
// wb_uart: Wishbone slave 8N1 UART with a FIFO-buffered transmitter and a
// single-byte receive holding register carrying sticky error flags.
module wb_uart #(
    parameter logic [31:0] BASE_ADDRESS = 32'h0300_0100,
    parameter int unsigned TX_DEPTH     = 16,
    parameter int unsigned DEFAULT_DIV  = 104
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    output logic        ser_tx,
    input  logic        ser_rx
);
    localparam int unsigned AW   = $clog2(TX_DEPTH);
    localparam int unsigned CW   = AW + 1;
    localparam int unsigned DIVW = 16;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_DONE} rx_state_e;

    logic            ack_q;
    logic [31:0]     rdata_q;
    logic [DIVW-1:0] div_q;
    logic            tx_ovf_q;

    logic [7:0]      fifo_mem_q [TX_DEPTH];
    logic [CW-1:0]   wr_ptr_q, rd_ptr_q;

    tx_state_e       tx_state_q;
    logic [DIVW-1:0] tx_cnt_q, tx_div_q;
    logic [2:0]      tx_bit_q;
    logic [7:0]      tx_shift_q;
    logic            ser_tx_q;
    logic            tx_idle_q;

    rx_state_e       rx_state_q;
    logic            rx_s1_q, rx_s2_q, rx_prev_q;
    logic [DIVW-1:0] rx_cnt_q, rx_div_q;
    logic [2:0]      rx_bit_q;
    logic [7:0]      rx_shift_q;
    logic            rx_stop_ok_q;
    logic            rx_valid_q, rx_overrun_q, rx_frame_err_q;
    logic [7:0]      rx_byte_q;

    // Bus decode: one side effect per access, guarded by the pending ack.
    logic          sel_c, access_c, rd_c, wr_c;
    logic [1:0]    reg_c;
    logic          push_c, data_rd_c, stat_wr_c, div_wr_c;
    logic [CW-1:0] count_c;
    logic          full_c, empty_c, tx_load_c;
    logic [31:0]   status_c;
    logic          unused_bits;

    assign sel_c     = i_wb_cyc && i_wb_stb && (i_wb_addr[31:4] == BASE_ADDRESS[31:4]);
    assign access_c  = sel_c && !ack_q;
    assign reg_c     = i_wb_addr[3:2];
    assign wr_c      = access_c && i_wb_we;
    assign rd_c      = access_c && !i_wb_we;
    assign push_c    = wr_c && (reg_c == 2'd0);
    assign data_rd_c = rd_c && (reg_c == 2'd0);
    assign stat_wr_c = wr_c && (reg_c == 2'd1);
    assign div_wr_c  = wr_c && (reg_c == 2'd2);

    assign count_c = wr_ptr_q - rd_ptr_q;
    assign full_c  = (count_c == CW'(TX_DEPTH));
    assign empty_c = (count_c == '0);

    // The stop bit's last cycle reloads directly so queued frames run back to back.
    assign tx_load_c = !empty_c &&
                       ((tx_state_q == TX_IDLE) ||
                        ((tx_state_q == TX_STOP) && (tx_cnt_q == '0)));

    assign unused_bits = ^{i_wb_addr[1:0], i_wb_data[31:16]};

    always_comb begin
        status_c          = '0;
        status_c[0]       = full_c;
        status_c[1]       = tx_idle_q;
        status_c[2]       = rx_valid_q;
        status_c[3]       = tx_ovf_q;
        status_c[4]       = rx_overrun_q;
        status_c[5]       = rx_frame_err_q;
        status_c[16 +: CW] = count_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            div_q    <= DIVW'(DEFAULT_DIV);
            tx_ovf_q <= 1'b0;
        end else begin
            ack_q   <= access_c;
            rdata_q <= '0;
            if (rd_c) begin
                case (reg_c)
                    2'd0:    rdata_q <= {23'b0, rx_valid_q, rx_byte_q};
                    2'd1:    rdata_q <= status_c;
                    2'd2:    rdata_q <= {16'b0, div_q};
                    default: rdata_q <= '0;
                endcase
            end
            if (push_c && full_c) begin
                tx_ovf_q <= 1'b1;
            end else if (stat_wr_c && i_wb_data[3]) begin
                tx_ovf_q <= 1'b0;
            end
            if (div_wr_c) begin
                div_q <= (i_wb_data[15:0] < 16'd4) ? 16'd4 : i_wb_data[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_c && !full_c) wr_ptr_q <= wr_ptr_q + CW'(1);
            if (tx_load_c)         rd_ptr_q <= rd_ptr_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_c && !full_c) fifo_mem_q[wr_ptr_q[AW-1:0]] <= i_wb_data[7:0];
    end

    // Transmitter; ser_tx is registered from the state, so the line lags the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            ser_tx_q   <= 1'b1;
            tx_idle_q  <= 1'b1;
        end else begin
            tx_idle_q <= (tx_state_q == TX_IDLE) && empty_c;
            case (tx_state_q)
                TX_START: ser_tx_q <= 1'b0;
                TX_DATA:  ser_tx_q <= tx_shift_q[0];
                default:  ser_tx_q <= 1'b1;
            endcase
            if (tx_load_c) begin
                tx_state_q <= TX_START;
                tx_div_q   <= div_q;
                tx_cnt_q   <= div_q - DIVW'(1);
                tx_shift_q <= fifo_mem_q[rd_ptr_q[AW-1:0]];
            end else begin
                case (tx_state_q)
                    TX_START: begin
                        if (tx_cnt_q == '0) begin
                            tx_state_q <= TX_DATA;
                            tx_bit_q   <= '0;
                            tx_cnt_q   <= tx_div_q - DIVW'(1);
                        end else begin
                            tx_cnt_q <= tx_cnt_q - DIVW'(1);
                        end
                    end
                    TX_DATA: begin
                        if (tx_cnt_q == '0) begin
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_cnt_q   <= tx_div_q - DIVW'(1);
                            if (tx_bit_q == 3'd7) tx_state_q <= TX_STOP;
                            else                  tx_bit_q   <= tx_bit_q + 3'd1;
                        end else begin
                            tx_cnt_q <= tx_cnt_q - DIVW'(1);
                        end
                    end
                    TX_STOP: begin
                        if (tx_cnt_q == '0) tx_state_q <= TX_IDLE;
                        else                tx_cnt_q   <= tx_cnt_q - DIVW'(1);
                    end
                    default: tx_state_q <= TX_IDLE;
                endcase
            end
        end
    end

    // Receiver and its holding register; a byte landing with a DATA read keeps rx_valid set.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1_q        <= 1'b1;
            rx_s2_q        <= 1'b1;
            rx_prev_q      <= 1'b1;
            rx_state_q     <= RX_IDLE;
            rx_cnt_q       <= '0;
            rx_div_q       <= '0;
            rx_bit_q       <= '0;
            rx_shift_q     <= '0;
            rx_stop_ok_q   <= 1'b0;
            rx_valid_q     <= 1'b0;
            rx_overrun_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
            rx_byte_q      <= '0;
        end else begin
            rx_s1_q   <= ser_rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            if (data_rd_c) rx_valid_q <= 1'b0;
            if (stat_wr_c && i_wb_data[4]) rx_overrun_q   <= 1'b0;
            if (stat_wr_c && i_wb_data[5]) rx_frame_err_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_state_q <= RX_START;
                        rx_div_q   <= div_q;
                        rx_cnt_q   <= (div_q >> 1) - DIVW'(1);
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == '0) begin
                        if (rx_s2_q) begin
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_state_q <= RX_DATA;
                            rx_bit_q   <= '0;
                            rx_cnt_q   <= rx_div_q - DIVW'(1);
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - DIVW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == '0) begin
                        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                        rx_cnt_q   <= rx_div_q - DIVW'(1);
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                        else                  rx_bit_q   <= rx_bit_q + 3'd1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - DIVW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == '0) begin
                        rx_stop_ok_q <= rx_s2_q;
                        rx_state_q   <= RX_DONE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - DIVW'(1);
                    end
                end
                RX_DONE: begin
                    rx_state_q <= RX_IDLE;
                    if (rx_stop_ok_q) begin
                        rx_byte_q  <= rx_shift_q;
                        rx_valid_q <= 1'b1;
                        if (rx_valid_q && !data_rd_c) rx_overrun_q <= 1'b1;
                    end else begin
                        rx_frame_err_q <= 1'b1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign o_wb_ack  = ack_q;
    assign o_wb_data = rdata_q;
    assign ser_tx    = ser_tx_q;
endmodule

// File: doc/wb_uart.md
# wb_uart

Wishbone-slave 8N1 UART peripheral for the icebreaker SoC: sits on the shared Wishbone bus behind the iomem→Wishbone bridge, alongside wb_buttons_leds and vga_core, and drives the board serial pins. Transmit path is buffered by a TX FIFO; receive path holds one byte with sticky error flags. Its Wishbone data and ack outputs are OR-combined with the other slaves, so both outputs are zero whenever this block is not acknowledging.

## Interface
- BASE_ADDRESS, 32'h0300_0100, register window base; the block decodes 16 bytes.
- TX_DEPTH, 16, TX FIFO depth in bytes; must be a power of two, 2..256.
- DEFAULT_DIV, 104, reset value of the clock divider in clk cycles per bit (12 MHz / 115200).
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- i_wb_cyc  input  1  Wishbone cycle.
- i_wb_stb  input  1  Wishbone strobe.
- i_wb_we  input  1  write enable.
- i_wb_addr  input  32  byte address.
- i_wb_data  input  32  write data.
- o_wb_ack  output  1  acknowledge, registered.
- o_wb_data  output  32  read data; zero except in the ack cycle of a read.
- ser_tx  output  1  UART transmit, idle high.
- ser_rx  input  1  UART receive, asynchronous.

## Operation
- Select: i_wb_cyc & i_wb_stb & (i_wb_addr[31:4] == BASE_ADDRESS[31:4]). Offset i_wb_addr[3:2] selects the register.
- Access: on a clock edge with select high and o_wb_ack low, set o_wb_ack = 1 for exactly one cycle and perform the side effect once. Unselected accesses are not acked.
- Offset 0 DATA:
  - Write pushes i_wb_data[7:0] to the TX FIFO. If the FIFO is full, the byte is dropped and tx_overflow is set.
  - Read returns {23'b0, rx_valid, rx_byte}, then clears rx_valid.
- Offset 1 STATUS, read: [0] tx_full, [1] tx_idle (FIFO empty and TX engine idle), [2] rx_valid, [3] tx_overflow, [4] rx_overrun, [5] rx_frame_err, [16+:N] TX FIFO count, where N = log2(TX_DEPTH)+1. All other bits are 0.
- Offset 1 STATUS, write: a 1 in bit 3, 4 or 5 clears that sticky flag (write-1-to-clear).
- Offset 2 CLKDIV: holds a 16-bit divider, readable in [15:0]. A write stores i_wb_data[15:0]; a value below 4 stores 4.
- Offset 3: reserved. Acked; reads return 0; writes are ignored.
- TX engine states:
  - IDLE: if the FIFO is not empty, pop a byte, latch CLKDIV, go to START.
  - START: ser_tx = 0.
  - DATA: bits 0..7, LSB first.
  - STOP: ser_tx = 1.
  - Each bit lasts exactly the latched divider value in cycles. After STOP, go to IDLE, which pops immediately if data is waiting, so frames are back to back with no gap.
- RX engine:
  - ser_rx passes through a 2-FF synchronizer.
  - IDLE: a falling edge latches CLKDIV (D) and goes to START.
  - START: after floor(D/2) cycles, sample. If high, treat as a glitch and go back to IDLE. If low, go to DATA.
  - DATA: sample 8 bits at D-cycle intervals, LSB first.
  - STOP: sample D cycles after the last data bit.
    - Stop high: on the next cycle, store the byte and set rx_valid. If rx_valid was already set, set rx_overrun; the new byte overwrites the old one.
    - Stop low: discard the byte and set rx_frame_err.
  - Return to IDLE on the cycle after the stop sample.
- Simultaneous events: a byte arriving in the same cycle as a DATA read ack wins. rx_valid ends at 1, and rx_overrun is not set.
- Reset (at any time, including mid-frame):
  - ser_tx = 1 and the frame is aborted.
  - FIFO is emptied; all flags and rx_byte are cleared.
  - CLKDIV = DEFAULT_DIV.
  - o_wb_ack = 0 and o_wb_data = 0.
  - Both engines go to IDLE.

## Timing
- Ack latency: 1 cycle after select is first seen. The bridge drops strobe on the edge after it samples ack; the !o_wb_ack guard prevents a double ack.
- Read data: valid only in the ack cycle.
- TX start: with TX idle and the FIFO empty, the write lands at the ack edge. ser_tx goes low exactly 2 cycles after the ack cycle.
- Frame length: 10·D cycles. tx_idle rises 1 cycle after the stop bit ends when the FIFO is empty.
- FIFO full/empty: wrap-around pointers with an extra MSB. tx_full reflects the push of the current write from the next cycle on.
- RX byte: visible in STATUS 1 cycle after the stop sample. Synchronizer latency is 2 cycles.

## Test plan
- Reset, then read STATUS → 0x0000_0002; read CLKDIV → 104; ser_tx = 1; o_wb_data = 0 outside every ack.
- CLKDIV = 4, write DATA 0xA5 → ser_tx low 2 cycles after ack, then bits 1,0,1,0,0,1,0,1, stop bit; each bit 4 cycles; tx_idle = 1 after 40 cycles.
- CLKDIV = 4, write TX_DEPTH+1 bytes back to back while TX is busy → one byte dropped, tx_overflow = 1; write STATUS 0x8 → flag cleared; frames are contiguous with no idle gap.
- CLKDIV = 8, drive 0x3C on ser_rx → STATUS bit 2 = 1; DATA read → 0x13C; second DATA read → 0x03C.
- Two RX frames with no read in between → rx_overrun = 1, DATA = second byte. Frame with stop bit low → rx_frame_err = 1, rx_valid unchanged. 3-cycle low glitch with D = 8 → no byte, no flag.
- Assert reset mid TX frame → ser_tx = 1 next cycle, FIFO count = 0. Access at BASE_ADDRESS+0x10 → no ack.
